// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the up/down modulo counter: width helper and direction encoding.
package counter_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} count_dir_t;

    // ceil(log2(x)), never less than 1 so a two-state counter still gets a bit
    function automatic int CeilLog2(input int x);
        int r;
        int v;
        r = 0;
        v = x - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with runtime terminal value, load, clear, wrap pulse and
// a saturating wrap counter for cascading timebases.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int MAXIMUM_VALUE     = 32,
    parameter int NBITS_FOR_COUNTER = CeilLog2(MAXIMUM_VALUE),
    parameter int WRAP_BITS         = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         load,
    input  logic [NBITS_FOR_COUNTER-1:0] load_value,
    input  logic                         up_down,
    input  logic [NBITS_FOR_COUNTER-1:0] terminal_value,
    output logic [NBITS_FOR_COUNTER-1:0] count,
    output logic                         flag_zero,
    output logic                         flag_max,
    output logic                         wrap_pulse,
    output logic [WRAP_BITS-1:0]         wrap_count
);

    localparam logic [NBITS_FOR_COUNTER-1:0] TOP_LIMIT = NBITS_FOR_COUNTER'(MAXIMUM_VALUE - 1);
    localparam logic [WRAP_BITS-1:0]         WRAP_SAT  = {WRAP_BITS{1'b1}};

    logic [NBITS_FOR_COUNTER-1:0] count_reg;
    logic                         wrap_pulse_reg;
    logic [WRAP_BITS-1:0]         wrap_count_reg;

    logic [NBITS_FOR_COUNTER-1:0] terminal_eff;
    logic [NBITS_FOR_COUNTER-1:0] load_eff;
    logic [NBITS_FOR_COUNTER-1:0] step_next;
    logic                         step_wrap;
    count_dir_t                   dir;

    always_comb begin
        terminal_eff = (terminal_value > TOP_LIMIT) ? TOP_LIMIT : terminal_value;
        load_eff     = (load_value > terminal_eff) ? terminal_eff : load_value;
        dir          = count_dir_t'(up_down);
        step_next    = count_reg;
        step_wrap    = 1'b0;
        if (dir == DIR_UP) begin
            // ">=" also catches a terminal lowered beneath the current count
            if (count_reg >= terminal_eff) begin
                step_next = '0;
                step_wrap = 1'b1;
            end else begin
                step_next = count_reg + 1'b1;
            end
        end else begin
            if (count_reg == '0) begin
                step_next = terminal_eff;
                step_wrap = 1'b1;
            end else if (count_reg > terminal_eff) begin
                step_next = terminal_eff;
            end else begin
                step_next = count_reg - 1'b1;
            end
        end
        flag_zero = (count_reg == '0);
        flag_max  = (count_reg == terminal_eff);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg      <= '0;
            wrap_pulse_reg <= 1'b0;
            wrap_count_reg <= '0;
        end else if (load) begin
            count_reg      <= load_eff;
            wrap_pulse_reg <= 1'b0;
        end else if (enable) begin
            count_reg      <= step_next;
            wrap_pulse_reg <= step_wrap;
            if (step_wrap && (wrap_count_reg != WRAP_SAT)) begin
                wrap_count_reg <= wrap_count_reg + 1'b1;
            end
        end else begin
            wrap_pulse_reg <= 1'b0;
        end
    end

    assign count      = count_reg;
    assign wrap_pulse = wrap_pulse_reg;
    assign wrap_count = wrap_count_reg;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: the driver queues the expected post-edge state, a monitor pops and compares.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_value = '0;
    logic       up_down = 1'b1;
    logic [4:0] terminal_value = 5'd31;

    logic [4:0] count_a;
    logic       zero_a, max_a, pulse_a;
    logic [7:0] wc_a;
    logic [4:0] count_b;
    logic       zero_b, max_b, pulse_b;
    logic [1:0] wc_b;

    always #5 clk = ~clk;

    mod_updown_counter #(.MAXIMUM_VALUE(32), .WRAP_BITS(8)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down), .terminal_value(terminal_value),
        .count(count_a), .flag_zero(zero_a), .flag_max(max_a),
        .wrap_pulse(pulse_a), .wrap_count(wc_a)
    );

    mod_updown_counter #(.MAXIMUM_VALUE(20), .WRAP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down), .terminal_value(terminal_value),
        .count(count_b), .flag_zero(zero_b), .flag_max(max_b),
        .wrap_pulse(pulse_b), .wrap_count(wc_b)
    );

    typedef struct {
        int         sel;
        logic [4:0] cnt;
        logic       zf;
        logic       mf;
        logic       wp;
        logic [7:0] wc;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    logic stim_done = 1'b0;

    task automatic chk(input string name, input string field, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
        end
    endtask

    // Monitor: the counter presents a new state after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel == 0) begin
                    chk(e.name, "count", count_a, e.cnt);
                    chk(e.name, "zero", zero_a, e.zf);
                    chk(e.name, "max", max_a, e.mf);
                    chk(e.name, "pulse", pulse_a, e.wp);
                    chk(e.name, "wraps", wc_a, e.wc);
                    $display("dut_a %s: count=%0d z=%0d m=%0d p=%0d wc=%0d", e.name,
                             count_a, zero_a, max_a, pulse_a, wc_a);
                end else begin
                    chk(e.name, "count", count_b, e.cnt);
                    chk(e.name, "zero", zero_b, e.zf);
                    chk(e.name, "max", max_b, e.mf);
                    chk(e.name, "pulse", pulse_b, e.wp);
                    chk(e.name, "wraps", {6'd0, wc_b}, e.wc);
                    $display("dut_b %s: count=%0d z=%0d m=%0d p=%0d wc=%0d", e.name,
                             count_b, zero_b, max_b, pulse_b, wc_b);
                end
            end
        end
    end

    task automatic drv(input logic rs, input logic cl, input logic ld, input logic [4:0] lv,
                       input logic ud, input logic en, input logic [4:0] tv, input int sel,
                       input logic [4:0] ec, input logic ez, input logic em, input logic ep,
                       input logic [7:0] ew, input string name);
        exp_t e;
        @(negedge clk);
        reset = rs; clear = cl; load = ld; load_value = lv;
        up_down = ud; enable = en; terminal_value = tv;
        e.sel = sel; e.cnt = ec; e.zf = ez; e.mf = em; e.wp = ep; e.wc = ew; e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        // reset, terminal 31
        drv(1, 0, 0, 0, 1, 0, 31, 0, 0, 1, 0, 0, 0, "reset");
        // full up sweep and wrap
        for (int k = 1; k <= 31; k++)
            drv(0, 0, 0, 0, 1, 1, 31, 0, 5'(k), 0, (k == 31), 0, 0, "up_sweep");
        drv(0, 0, 0, 0, 1, 1, 31, 0, 0, 1, 0, 1, 1, "up_wrap");
        drv(0, 0, 0, 0, 1, 0, 31, 0, 0, 1, 0, 0, 1, "hold");
        // down sweep with terminal 9
        drv(0, 0, 0, 0, 0, 1, 9, 0, 9, 0, 1, 1, 2, "down_wrap1");
        for (int k = 8; k >= 0; k--)
            drv(0, 0, 0, 0, 0, 1, 9, 0, 5'(k), (k == 0), 0, 0, 2, "down_sweep");
        drv(0, 0, 0, 0, 0, 1, 9, 0, 9, 0, 1, 1, 3, "down_wrap2");
        // load clamps and beats enable
        drv(0, 0, 1, 20, 0, 0, 9, 0, 9, 0, 1, 0, 3, "load_clamp");
        drv(0, 0, 1, 4, 0, 1, 9, 0, 4, 0, 0, 0, 3, "load_over_en");
        // terminal lowered below count
        drv(0, 0, 1, 12, 1, 0, 31, 0, 12, 0, 0, 0, 3, "load12");
        drv(0, 0, 0, 0, 1, 1, 5, 0, 0, 1, 0, 1, 4, "lower_up");
        drv(0, 0, 1, 12, 1, 0, 31, 0, 12, 0, 0, 0, 4, "load12b");
        drv(0, 0, 0, 0, 0, 1, 5, 0, 5, 0, 1, 0, 4, "lower_down");
        // clear priority, then mid-count reset
        drv(0, 1, 1, 7, 1, 1, 31, 0, 0, 1, 0, 0, 0, "clear_prio");
        drv(0, 0, 1, 0, 0, 0, 31, 0, 0, 1, 0, 0, 0, "load0");
        drv(0, 0, 0, 0, 0, 1, 31, 0, 31, 0, 1, 1, 1, "down_wrap3");
        drv(0, 0, 1, 17, 0, 0, 31, 0, 17, 0, 0, 0, 1, "load17");
        drv(1, 0, 0, 0, 1, 1, 31, 0, 0, 1, 0, 0, 0, "reset_mid");
        // second instance: 2-bit saturating wraps, MAXIMUM_VALUE=20
        drv(1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, "b_reset");
        for (int k = 1; k <= 6; k++)
            drv(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, (k < 3) ? 8'(k) : 8'd3, "b_sat");
        drv(0, 0, 1, 25, 1, 0, 30, 1, 19, 0, 1, 0, 3, "b_clamp_load");
        drv(0, 0, 0, 0, 1, 1, 30, 1, 0, 1, 0, 1, 3, "b_clamp_wrap");
        drv(0, 0, 0, 0, 0, 1, 30, 1, 19, 0, 1, 1, 3, "b_clamp_down");
        drv(0, 0, 0, 0, 1, 0, 30, 1, 19, 0, 1, 0, 3, "b_hold");
        stim_done = 1'b1;
    end

    initial begin
        int guard;
        guard = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        #2;
        chk("drain", "pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
